// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. One full-adder cell (two half
// adders) is reused across WIDTH cycles, LSB first, with a registered carry.
`timescale 1ns/1ps
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Shared cell half: returns {carry, sum}.
  function automatic logic [1:0] half_adder(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [1:0]       ha1, ha2;
  logic             bit_s;
  logic             carry_new;
  logic [WIDTH-1:0] s_sh_next;

  // Full-adder cell built from two half-adder stages, and the shifted sum.
  always_comb begin
    ha1       = half_adder(a_sh_q[0], b_sh_q[0]);
    ha2       = half_adder(ha1[0], carry_q);
    bit_s     = ha2[0];
    carry_new = ha1[1] | ha2[1];
    // New bit enters at the MSB; after WIDTH steps the first bit sits at LSB.
    s_sh_next = WIDTH'({bit_s, s_sh_q} >> 1);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          s_sh_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = s_sh_next;
        carry_d = carry_new;
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_sh_next;
          cout_d  = carry_new;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8 instance plus a WIDTH=1 instance).
`timescale 1ns/1ps
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_asserts;
  int n_fail;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait up to 'limit' edges for done; returns number of edges waited.
  task automatic wait_done(input int limit, output int k);
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // One complete addition on the WIDTH=8 instance; inputs scrambled during RUN.
  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input string tag);
    logic [8:0] e;
    int k;
    e = 9'(av) + 9'(bv) + 9'(ci);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(20, k);
    check({tag, " latency"}, 32'(k), 32'd8);
    check({tag, " sum"}, 32'(sum), 32'(e[7:0]));
    check({tag, " cout"}, 32'(cout), 32'(e[8]));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, " done_cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    int k;
    logic [7:0] prev_sum;
    n_asserts = 0;
    n_fail    = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // 1. Reset
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'h00);
    check("rst cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst busy", 32'(busy), 32'd0);
    check("post_rst done", 32'(done), 32'd0);
    check("post_rst sum", 32'(sum), 32'h00);
    check("w1 rst sum", 32'(sum1), 32'd0);
    check("w1 rst busy", 32'(busy1), 32'd0);

    // 2. Basic add with full latency check
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;              // E0
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("t2 busy_run", 32'(busy), 32'd1);
      check("t2 done_low", 32'(done), 32'd0);
      @(posedge clk); #1;            // E0+i
    end
    check("t2 done_at_E0+8", 32'(done), 32'd1);
    check("t2 busy_at_E0+8", 32'(busy), 32'd0);
    check("t2 sum", 32'(sum), 32'h7F);
    check("t2 cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    check("t2 done_pulse_1cyc", 32'(done), 32'd0);
    check("t2 sum_held", 32'(sum), 32'h7F);

    // 3. Carry ripple cases
    run_add(8'hFF, 8'h01, 1'b1, "t3a");
    run_add(8'hFF, 8'hFF, 1'b1, "t3b");

    // 4a. start re-asserted mid-RUN is ignored; old result held during RUN
    prev_sum = sum;
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;              // E0
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;              // E0+2
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;              // E0+3
    start = 1'b0;
    check("t4 prev_sum_held", 32'(sum), 32'(prev_sum));
    check("t4 prev_cout_held", 32'(cout), 32'd1);
    wait_done(20, k);
    check("t4 latency_ignored_start", 32'(k), 32'd5);
    check("t4 sum", 32'(sum), 32'h7F);
    @(posedge clk); #1;
    check("t4 no_restart", 32'(busy), 32'd0);

    // 4b. start held high through DONE: second completion at E0+17
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;              // E0
    a = 8'h12; b = 8'h34; cin = 1'b1;
    wait_done(20, k);
    check("t4b first_latency", 32'(k), 32'd8);
    check("t4b first_sum", 32'(sum), 32'h7F);
    @(posedge clk); #1;              // E0+9: accepted from DONE
    start = 1'b0;
    check("t4b busy_after_done_accept", 32'(busy), 32'd1);
    check("t4b done_cleared", 32'(done), 32'd0);
    k = 9;
    while (done !== 1'b1 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("t4b second_done_E0+17", 32'(k), 32'd17);
    check("t4b second_sum", 32'(sum), 32'h47);
    check("t4b second_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    // 5. Reset mid-RUN aborts
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;              // E0
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("t5 abort busy", 32'(busy), 32'd0);
    check("t5 abort sum", 32'(sum), 32'h00);
    check("t5 abort cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) k++;
    end
    check("t5 no_done_after_abort", 32'(k), 32'd0);
    run_add(8'h10, 8'h20, 1'b0, "t5 next_add");

    // 6. Random sweep against a + b + cin
    for (int n = 0; n < 1000; n++) begin
      run_add(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "t6 rand");
    end

    // 6b. WIDTH=1 instance: 1+1+1
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;              // E0
    start1 = 1'b0;
    check("w1 busy", 32'(busy1), 32'd1);
    check("w1 done_early", 32'(done1), 32'd0);
    @(posedge clk); #1;              // E0+1
    check("w1 done", 32'(done1), 32'd1);
    check("w1 sum", 32'(sum1), 32'd1);
    check("w1 cout", 32'(cout1), 32'd1);
    check("w1 busy_low", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    check("w1 done_cleared", 32'(done1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
